// File: rtl/rx_if.sv
// Byte-stream bundle between the serial receiver and its consumer, plus the serial line itself.
interface rx_if;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    // valid/ready: a byte moves on every rising edge where valid && ready; data is stable while valid is high.
    modport master (
        input  rxd,
        input  ready,
        output data,
        output valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output rxd,
        output ready,
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/rx.sv
// UART receiver (start 0, 8 data bits LSB first, stop 1) with a valid/ready holding register.
// Define RX_SYNC_EN to pass rxd through a 2-flop synchronizer for asynchronous pins.
module rx #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       nrst,
    rx_if.master       bus,
    output logic [2:0] state_o
);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((HALF > 0) ? HALF - 1 : 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic rxd_s;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], bus.rxd};
    end
    assign rxd_s = sync_q[1];
`else
    assign rxd_s = bus.rxd;
`endif

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitn_q, bitn_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bitn_d  = bitn_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q;

        if (valid_q && bus.ready) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rxd_s) begin
                    if (HALF == 0) begin
                        state_d = S_DATA;
                        cnt_d   = CNT_BIT;
                        bitn_d  = 3'd0;
                    end else begin
                        state_d = S_START;
                        cnt_d   = CNT_HALF;
                    end
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rxd_s) begin
                    state_d = S_DATA;
                    cnt_d   = CNT_BIT;
                    bitn_d  = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rxd_s, shift_q[7:1]};
                    cnt_d   = CNT_BIT;
                    if (bitn_q == 3'd7) state_d = S_STOP;
                    else                bitn_d  = bitn_q + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxd_s) begin
                    // A byte consumed on this same edge frees the register for the new one.
                    if (!valid_q || bus.ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = S_BREAK;
                end
            end
            S_BREAK: begin
                if (rxd_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bitn_q  <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign state_o       = state_q;
endmodule
